prf_wb_arb: RTL and testbench

PRF_WB_ARB -- requirements
Module: prf_wb_arb

---
 rtl/prf_wb_arb.sv | 143 ++++++++++++++
 tb/tb_prf_wb_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : prf_wb_arb
// Purpose  : Physical-register-file write-back arbiter. Results from
//            IN_PORTS producers are collected into a circular queue of DEPTH
//            entries and retired onto W_PORTS PRF write ports, oldest first.
//            The PRF never stalls, so up to W_PORTS entries leave every cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid_i    per producer: result presented
//   in_prn_i      per producer: destination PRN
//   in_data_i     per producer: 64-bit result
//   in_ready_o    per producer: result accepted this cycle if valid
//   wb_wen_o      per PRF port: write enable
//   wb_wprn_o     per PRF port: write PRN (0 when disabled)
//   wb_wdata_o    per PRF port: write data (0 when disabled)
//   occupancy_o   registered queue entry count
//   stall_cnt_o   saturating count of back-pressure cycles
// ============================================================================
module prf_wb_arb #(
  parameter int IN_PORTS = 4,
  parameter int W_PORTS  = 2,
  parameter int PRN_BITS = 6,
  parameter int DEPTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_PORTS-1:0]                  in_valid_i,
  input  logic [IN_PORTS-1:0][PRN_BITS-1:0]    in_prn_i,
  input  logic [IN_PORTS-1:0][63:0]            in_data_i,
  output logic [IN_PORTS-1:0]                  in_ready_o,
  output logic [W_PORTS-1:0]                   wb_wen_o,
  output logic [W_PORTS-1:0][PRN_BITS-1:0]     wb_wprn_o,
  output logic [W_PORTS-1:0][63:0]             wb_wdata_o,
  output logic [$clog2(DEPTH):0]               occupancy_o,
  output logic [31:0]                          stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage: not reset, only entries inside [head, head+count) matter.
  logic [PRN_BITS-1:0] mem_prn_q  [DEPTH];
  logic [63:0]         mem_data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      stall_q, stall_d;

  logic [CNT_W-1:0]               w_free;
  logic [CNT_W-1:0]               w_accepted;
  logic [CNT_W-1:0]               w_drained;
  logic [IN_PORTS-1:0]            w_push;
  logic [IN_PORTS-1:0][PTR_W-1:0] w_slot;
  logic                           w_stall;

  // Ready depends on registered count only, so slots freed by this cycle's
  // drain become visible to producers one cycle later.
  assign w_free = CNT_W'(DEPTH) - count_q;

  for (genvar i = 0; i < IN_PORTS; i++) begin : g_ready
    assign in_ready_o[i] = (w_free > CNT_W'(i));
  end

  // Accepted ports are packed onto consecutive tail slots in ascending port
  // order. Because ready is a prefix of ports, this keeps producer order.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc    = '0;
    w_push = '0;
    w_slot = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      w_push[i] = in_valid_i[i] & in_ready_o[i];
      w_slot[i] = PTR_W'({1'b0, tail_q} + acc);
      if (w_push[i]) begin
        acc = acc + CNT_W'(1);
      end
    end
    w_accepted = acc;
  end

  // Drain is based on registered count, so an entry written this edge can
  // never be popped on the same edge.
  assign w_drained = (count_q > CNT_W'(W_PORTS)) ? CNT_W'(W_PORTS) : count_q;

  assign w_stall = |(in_valid_i & ~in_ready_o);

  always_comb begin
    head_d  = PTR_W'({1'b0, head_q} + w_drained);
    tail_d  = PTR_W'({1'b0, tail_q} + w_accepted);
    count_d = count_q + w_accepted - w_drained;
    stall_d = stall_q;
    if (w_stall && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Accepted slots are always outside the live window (free >= accepted),
  // so writes never clobber an entry still waiting to drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < IN_PORTS; i++) begin
        if (w_push[i]) begin
          mem_prn_q[w_slot[i]]  <= in_prn_i[i];
          mem_data_q[w_slot[i]] <= in_data_i[i];
        end
      end
    end
  end

  // Port j shows entry head+j; older results land on lower ports, so for a
  // duplicate PRN the younger write sits on the higher port and wins.
  for (genvar j = 0; j < W_PORTS; j++) begin : g_wb
    logic [PTR_W-1:0] w_rd_idx;
    assign w_rd_idx      = PTR_W'({1'b0, head_q} + CNT_W'(j));
    assign wb_wen_o[j]   = (count_q > CNT_W'(j));
    assign wb_wprn_o[j]  = wb_wen_o[j] ? mem_prn_q[w_rd_idx]  : '0;
    assign wb_wdata_o[j] = wb_wen_o[j] ? mem_data_q[w_rd_idx] : '0;
  end

  assign occupancy_o = count_q;
  assign stall_cnt_o = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_prf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_prf_wb_arb
// Purpose  : Directed self-checking bench for prf_wb_arb: reset state, single
//            result, burst, back-pressure, mid-operation reset, duplicate PRN
//            ordering and a 20-entry stream across pointer wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prf_wb_arb;

  localparam int IN_PORTS = 4;
  localparam int W_PORTS  = 2;
  localparam int PRN_BITS = 6;
  localparam int DEPTH    = 8;

  logic                              clk;
  logic                              rst;
  logic [IN_PORTS-1:0]               in_valid;
  logic [IN_PORTS-1:0][PRN_BITS-1:0] in_prn;
  logic [IN_PORTS-1:0][63:0]         in_data;
  logic [IN_PORTS-1:0]               in_ready;
  logic [W_PORTS-1:0]                wb_wen;
  logic [W_PORTS-1:0][PRN_BITS-1:0]  wb_wprn;
  logic [W_PORTS-1:0][63:0]          wb_wdata;
  logic [$clog2(DEPTH):0]            occupancy;
  logic [31:0]                       stall_cnt;

  int checks   = 0;
  int failures = 0;

  prf_wb_arb #(
    .IN_PORTS (IN_PORTS),
    .W_PORTS  (W_PORTS),
    .PRN_BITS (PRN_BITS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_prn_i    (in_prn),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .wb_wen_o    (wb_wen),
    .wb_wprn_o   (wb_wprn),
    .wb_wdata_o  (wb_wdata),
    .occupancy_o (occupancy),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_prn   = '0;
    in_data  = '0;
  endtask

  initial begin
    logic [PRN_BITS-1:0] exp_prn_q [$];
    logic [63:0]         exp_data_q [$];
    int sent;
    int received;

    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_occ",    64'(occupancy), 64'd0);
    check("rst_wen",    64'(wb_wen),    64'd0);
    check("rst_wprn",   64'(wb_wprn),   64'd0);
    check("rst_wdata0", wb_wdata[0],    64'd0);
    check("rst_ready",  64'(in_ready),  64'hF);
    check("rst_stall",  64'(stall_cnt), 64'd0);

    // Single result
    in_valid   = 4'b0001;
    in_prn[0]  = 6'd5;
    in_data[0] = 64'h1234;
    step();
    clear_inputs();
    check("single_wen",    64'(wb_wen),     64'b01);
    check("single_prn0",   64'(wb_wprn[0]), 64'd5);
    check("single_data0",  wb_wdata[0],     64'h1234);
    check("single_prn1",   64'(wb_wprn[1]), 64'd0);
    check("single_data1",  wb_wdata[1],     64'd0);
    check("single_occ1",   64'(occupancy),  64'd1);
    step();
    check("single_occ0",   64'(occupancy),  64'd0);
    check("single_wen0",   64'(wb_wen),     64'd0);

    // Burst of four
    in_valid = 4'b1111;
    for (int i = 0; i < IN_PORTS; i++) begin
      in_prn[i]  = PRN_BITS'(i + 1);
      in_data[i] = 64'(8'h11 * (i + 1));
    end
    step();
    clear_inputs();
    check("burst_occ4",  64'(occupancy),   64'd4);
    check("burst_wen1",  64'(wb_wen),      64'b11);
    check("burst_a0",    64'(wb_wprn[0]),  64'd1);
    check("burst_a1",    64'(wb_wprn[1]),  64'd2);
    check("burst_ad1",   wb_wdata[1],      64'h22);
    step();
    check("burst_occ2",  64'(occupancy),   64'd2);
    check("burst_b0",    64'(wb_wprn[0]),  64'd3);
    check("burst_b1",    64'(wb_wprn[1]),  64'd4);
    check("burst_bd1",   wb_wdata[1],      64'h44);
    step();
    check("burst_wen0",  64'(wb_wen),      64'd0);
    check("burst_occ0",  64'(occupancy),   64'd0);

    // Back-pressure: all four ports valid every cycle
    in_valid = 4'b1111;
    for (int i = 0; i < IN_PORTS; i++) begin
      in_prn[i]  = PRN_BITS'(20 + i);
      in_data[i] = 64'(100 + i);
    end
    check("bp_occ0",    64'(occupancy), 64'd0);
    check("bp_ready0",  64'(in_ready),  64'hF);
    step();
    check("bp_occ4",    64'(occupancy), 64'd4);
    check("bp_ready4",  64'(in_ready),  64'hF);
    check("bp_stall0",  64'(stall_cnt), 64'd0);
    step();
    check("bp_occ6a",   64'(occupancy), 64'd6);
    check("bp_ready6",  64'(in_ready),  64'b0011);
    check("bp_stall0b", 64'(stall_cnt), 64'd0);
    step();
    check("bp_occ6b",   64'(occupancy), 64'd6);
    check("bp_stall1",  64'(stall_cnt), 64'd1);
    step();
    check("bp_occ6c",   64'(occupancy), 64'd6);
    check("bp_stall2",  64'(stall_cnt), 64'd2);
    check("bp_wen",     64'(wb_wen),    64'b11);

    // Reset mid-operation at occupancy 6
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_occ",   64'(occupancy), 64'd0);
    check("mrst_wen",   64'(wb_wen),    64'd0);
    check("mrst_wprn",  64'(wb_wprn),   64'd0);
    check("mrst_ready", 64'(in_ready),  64'hF);
    check("mrst_stall", 64'(stall_cnt), 64'd0);
    step();
    check("mrst_wen2",  64'(wb_wen),    64'd0);

    // Duplicate PRN in one cycle: ascending ports keep producer order
    in_valid   = 4'b0011;
    in_prn[0]  = 6'd7;
    in_data[0] = 64'hA;
    in_prn[1]  = 6'd7;
    in_data[1] = 64'hB;
    step();
    clear_inputs();
    check("dup_wen",   64'(wb_wen),     64'b11);
    check("dup_prn0",  64'(wb_wprn[0]), 64'd7);
    check("dup_data0", wb_wdata[0],     64'hA);
    check("dup_prn1",  64'(wb_wprn[1]), 64'd7);
    check("dup_data1", wb_wdata[1],     64'hB);
    step();
    check("dup_occ0",  64'(occupancy),  64'd0);

    // Stream 20 distinct PRNs, two per cycle, across pointer wrap
    sent     = 0;
    received = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int j = 0; j < W_PORTS; j++) begin
        if (wb_wen[j]) begin
          if (exp_prn_q.size() == 0) begin
            check("wrap_unexpected_wb", 64'(wb_wen), 64'd0);
          end else begin
            check("wrap_prn",  64'(wb_wprn[j]), 64'(exp_prn_q.pop_front()));
            check("wrap_data", wb_wdata[j],     exp_data_q.pop_front());
            received++;
          end
        end
      end
      clear_inputs();
      for (int p = 0; p < 2; p++) begin
        if (sent < 20) begin
          in_valid[p] = 1'b1;
          in_prn[p]   = PRN_BITS'(30 + sent);
          in_data[p]  = 64'hC0DE_0000 + 64'(sent);
          if (in_ready[p]) begin
            exp_prn_q.push_back(PRN_BITS'(30 + sent));
            exp_data_q.push_back(64'hC0DE_0000 + 64'(sent));
            sent++;
          end
        end
      end
      step();
      if (received == 20) break;
    end
    clear_inputs();
    check("wrap_received", 64'(received),  64'd20);
    check("wrap_occ0",     64'(occupancy), 64'd0);
    check("wrap_stall0",   64'(stall_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
